// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch-lookup and decode-resolution signals between the
//               pipeline (master) and the branch predictor (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
    // Fetch-stage lookup
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    // Decode-stage resolution
    logic        UpdateD;
    logic [31:0] PCD;
    logic        ConditionD;
    logic [31:0] TargetD;
    logic        PredTakenD;
    logic [31:0] PredTargetD;
    logic        MispredictD;
    logic [31:0] RedirectPCD;
    logic [15:0] MispredictCount;

    // Pipeline side: presents PCs and resolutions, consumes predictions
    modport master (
        output PCF, UpdateD, PCD, ConditionD, TargetD, PredTakenD, PredTargetD,
        input  PredTakenF, PredTargetF, MispredictD, RedirectPCD, MispredictCount
    );

    // Predictor side
    modport slave (
        input  PCF, UpdateD, PCD, ConditionD, TargetD, PredTakenD, PredTargetD,
        output PredTakenF, PredTargetF, MispredictD, RedirectPCD, MispredictCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               counters, fetch-stage prediction, decode-stage resolution
//               and a saturating mispredict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int IDX_BITS = 6
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    branch_predictor_if.slave bp
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam logic [1:0]  CTR_ALLOC = 2'b10;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Table storage, all flops
    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [1:0]          ctr_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Fetch lookup
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit;
    logic                f_taken;

    // Decode resolution
    logic [IDX_BITS-1:0] d_idx;
    logic [TAG_BITS-1:0] d_tag;
    logic                d_hit;
    logic [1:0]          ctr_d;
    logic                mispredict;

    // Byte-offset bits of the PCs play no part in indexing or tagging
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.PCF[1:0], bp.PCD[1:0]};

    assign f_idx = bp.PCF[IDX_BITS+1:2];
    assign f_tag = bp.PCF[31:IDX_BITS+2];
    assign d_idx = bp.PCD[IDX_BITS+1:2];
    assign d_tag = bp.PCD[31:IDX_BITS+2];

    // Fetch prediction reads pre-update table contents (no bypass)
    always_comb begin
        f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        f_taken = f_hit && ctr_q[f_idx][1];
    end

    assign bp.PredTakenF  = f_taken;
    assign bp.PredTargetF = f_taken ? tgt_q[f_idx] : (bp.PCF + 32'd4);

    // Resolution: hit detection, next counter value, mispredict and redirect
    always_comb begin
        d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
        ctr_d = ctr_q[d_idx];
        if (bp.ConditionD) begin
            if (ctr_q[d_idx] != 2'b11) ctr_d = ctr_q[d_idx] + 2'd1;
        end else begin
            if (ctr_q[d_idx] != 2'b00) ctr_d = ctr_q[d_idx] - 2'd1;
        end
        mispredict = bp.UpdateD &&
                     ((bp.PredTakenD != bp.ConditionD) ||
                      (bp.ConditionD && (bp.PredTargetD != bp.TargetD)));
    end

    assign bp.MispredictD = mispredict;
    assign bp.RedirectPCD = bp.ConditionD ? bp.TargetD : (bp.PCD + 32'd4);

    // Table update: train on hit, allocate on taken miss, ignore untaken miss
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= CTR_RESET;
                tgt_q[i]   <= '0;
            end
        end else if (bp.UpdateD) begin
            if (d_hit) begin
                ctr_q[d_idx] <= ctr_d;
                if (bp.ConditionD) tgt_q[d_idx] <= bp.TargetD;
            end else if (bp.ConditionD) begin
                valid_q[d_idx] <= 1'b1;
                tag_q[d_idx]   <= d_tag;
                ctr_q[d_idx]   <= CTR_ALLOC;
                tgt_q[d_idx]   <= bp.TargetD;
            end
        end
    end

    // Saturating mispredict counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 16'd1;
    end

    // Mispredict counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bp.MispredictCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_fail;
    int   n_total;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_BITS(6)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bp    (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic cond, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        bp.UpdateD     = 1'b1;
        bp.PCD         = pc;
        bp.ConditionD  = cond;
        bp.TargetD     = tgt;
        bp.PredTakenD  = ptaken;
        bp.PredTargetD = ptgt;
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bp.PCF  = 32'h0040_0010;
        bp.UpdateD     = 1'b0;
        bp.PCD         = 32'h0;
        bp.ConditionD  = 1'b0;
        bp.TargetD     = 32'h0;
        bp.PredTakenD  = 1'b0;
        bp.PredTargetD = 32'h0;
        #2;

        // Reset state
        check("rst_taken",  {31'd0, bp.PredTakenF}, 32'd0);
        check("rst_target", bp.PredTargetF, 32'h0040_0014);
        check("rst_count",  {16'd0, bp.MispredictCount}, 32'd0);

        // Update presented across an edge while reset is held: must be dropped
        resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        tick();
        check("rst_hold_count", {16'd0, bp.MispredictCount}, 32'd0);
        bp.UpdateD = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("rst_win_no_alloc", {31'd0, bp.PredTakenF}, 32'd0);

        // Taken miss allocates; mispredicted since predicted not-taken
        resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
        #1;
        check("alloc_mispredict", {31'd0, bp.MispredictD}, 32'd1);
        check("alloc_redirect",   bp.RedirectPCD, 32'h0040_0100);
        check("alloc_same_cycle", {31'd0, bp.PredTakenF}, 32'd0);
        tick();
        bp.UpdateD = 1'b0;
        check("alloc_taken",  {31'd0, bp.PredTakenF}, 32'd1);
        check("alloc_target", bp.PredTargetF, 32'h0040_0100);
        check("alloc_count",  {16'd0, bp.MispredictCount}, 32'd1);

        // Counter 10 -> 01 via not-taken (mispredicted)
        resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
        #1;
        check("nt1_mispredict", {31'd0, bp.MispredictD}, 32'd1);
        check("nt1_redirect",   bp.RedirectPCD, 32'h0040_0014);
        tick();
        check("nt1_taken",  {31'd0, bp.PredTakenF}, 32'd0);
        check("nt1_target", bp.PredTargetF, 32'h0040_0014);
        check("nt1_count",  {16'd0, bp.MispredictCount}, 32'd2);

        // 01 -> 00 -> 00, correctly predicted not-taken
        resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014);
        #1;
        check("nt2_no_mispredict", {31'd0, bp.MispredictD}, 32'd0);
        tick();
        tick();
        check("nt3_count", {16'd0, bp.MispredictCount}, 32'd2);

        // One taken from saturated 00 -> 01: still predicts not-taken
        resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
        tick();
        check("sat00_taken", {31'd0, bp.PredTakenF}, 32'd0);
        check("sat00_count", {16'd0, bp.MispredictCount}, 32'd3);

        // Second taken 01 -> 10: predicts taken
        tick();
        check("w2t_taken", {31'd0, bp.PredTakenF}, 32'd1);

        // Direction right, target wrong: mispredict, target retrained, counter 11
        resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
        #1;
        check("tgt_mispredict", {31'd0, bp.MispredictD}, 32'd1);
        tick();
        check("tgt_target", bp.PredTargetF, 32'h0040_0200);
        check("tgt_count",  {16'd0, bp.MispredictCount}, 32'd5);

        // Fully correct prediction, then UpdateD=0 with disagreeing fields
        resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
        #1;
        check("correct_no_mispredict", {31'd0, bp.MispredictD}, 32'd0);
        bp.UpdateD    = 1'b0;
        bp.PredTakenD = 1'b0;
        #1;
        check("idle_no_mispredict", {31'd0, bp.MispredictD}, 32'd0);
        tick();
        check("idle_count", {16'd0, bp.MispredictCount}, 32'd5);

        // Alias: same index, different tag, taken -> re-tagged
        resolve(32'h0040_1010, 1'b1, 32'h0040_2000, 1'b0, 32'h0040_1014);
        tick();
        bp.UpdateD = 1'b0;
        check("alias_old_taken",  {31'd0, bp.PredTakenF}, 32'd0);
        check("alias_old_target", bp.PredTargetF, 32'h0040_0014);
        bp.PCF = 32'h0040_1010;
        #1;
        check("alias_new_taken",  {31'd0, bp.PredTakenF}, 32'd1);
        check("alias_new_target", bp.PredTargetF, 32'h0040_2000);

        // Not-taken miss on the aliased old tag leaves the entry untouched
        resolve(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check("nt_miss_unchanged", bp.PredTargetF, 32'h0040_2000);

        // Same-cycle update and lookup at the same index (counter 10 -> 01)
        resolve(32'h0040_1010, 1'b0, 32'h0040_2000, 1'b1, 32'h0040_2000);
        #1;
        check("same_cycle_old", {31'd0, bp.PredTakenF}, 32'd1);
        tick();
        bp.UpdateD = 1'b0;
        check("same_cycle_new", {31'd0, bp.PredTakenF}, 32'd0);
        check("same_cycle_count", {16'd0, bp.MispredictCount}, 32'd7);

        // PC+4 wraps modulo 2^32
        bp.PCF = 32'hFFFF_FFFC;
        bp.PCD = 32'hFFFF_FFFC;
        bp.ConditionD = 1'b0;
        #1;
        check("wrap_predtarget", bp.PredTargetF, 32'h0);
        check("wrap_redirect",   bp.RedirectPCD, 32'h0);

        // Saturate the mispredict counter with untaken misses predicted taken
        resolve(32'h0080_0040, 1'b0, 32'h0, 1'b1, 32'h0);
        repeat (65535) @(posedge clk);
        #1;
        check("count_saturated", {16'd0, bp.MispredictCount}, 32'h0000_FFFF);
        tick();
        check("count_holds", {16'd0, bp.MispredictCount}, 32'h0000_FFFF);

        // Asynchronous reset mid-cycle
        bp.PCF = 32'h0040_0010;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count",  {16'd0, bp.MispredictCount}, 32'd0);
        check("async_rst_target", bp.PredTargetF, 32'h0040_0014);

        // First update after reset release is accepted
        resolve(32'h0040_0010, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        bp.UpdateD = 1'b0;
        check("first_upd_taken",  {31'd0, bp.PredTakenF}, 32'd1);
        check("first_upd_target", bp.PredTargetF, 32'h0040_0300);
        check("first_upd_count",  {16'd0, bp.MispredictCount}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 6, table index width (64 entries).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PCF  input  32  PC of instruction in fetch.
REQ-005 SHALL have port PredTakenF  output  1  fetch-stage prediction: branch taken.
REQ-006 SHALL have port PredTargetF  output  32  predicted next PC.
REQ-007 SHALL have port UpdateD  input  1  a conditional branch resolves in decode this cycle.
REQ-008 SHALL have port PCD  input  32  PC of the resolving branch.
REQ-009 SHALL have port ConditionD  input  1  resolved branch outcome, 1 = taken.
REQ-010 SHALL have port TargetD  input  32  computed branch target.
REQ-011 SHALL have port PredTakenD  input  1  prediction made for this branch in fetch, carried down the pipeline.
REQ-012 SHALL have port PredTargetD  input  32  predicted target carried down the pipeline.
REQ-013 SHALL have port MispredictD  output  1  resolution disagrees with prediction.
REQ-014 SHALL have port RedirectPCD  output  32  correct next PC after the branch.
REQ-015 SHALL have port MispredictCount  output  16  saturating count of mispredictions.

Function
REQ-016 SHALL hold 2^IDX_BITS entries, each containing valid, tag PC[31:IDX_BITS+2], a 2-bit counter, and a 32-bit target; all entries SHALL be flops.
REQ-017 SHALL index by PC[IDX_BITS+1:2]; hit = valid AND tag equal.
REQ-018 Counter encoding SHALL be: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-019 PredTakenF SHALL be combinational from PCF: hit AND counter[1].
REQ-020 PredTargetF SHALL be the entry target when PredTakenF=1, else PCF+4 (mod 2^32).
REQ-021 MispredictD SHALL be combinational: UpdateD AND ((PredTakenD != ConditionD) OR (ConditionD AND PredTargetD != TargetD)); it SHALL be 0 when UpdateD=0.
REQ-022 RedirectPCD SHALL be TargetD when ConditionD=1, else PCD+4 (mod 2^32); it is meaningful only when UpdateD=1.
REQ-023 On a rising edge with UpdateD=1 and a hit on PCD: counter +1 when taken, saturating at 11; counter -1 when not taken, saturating at 00; target <= TargetD only when taken.
REQ-024 On UpdateD=1, a miss and ConditionD=1: the entry SHALL be allocated (overwriting any other tag) with valid=1, tag from PCD, counter=10, target=TargetD.
REQ-025 On UpdateD=1, a miss and ConditionD=0: the table SHALL remain unchanged.
REQ-026 An update SHALL become visible to lookups from the next cycle; a same-cycle PCF lookup to the same index SHALL see pre-update contents.
REQ-027 Update latency SHALL be exactly one edge; no update SHALL occur when UpdateD=0.
REQ-028 MispredictCount SHALL increment by 1 on each edge where MispredictD=1 and SHALL hold at 0xFFFF (no wrap).

Reset
REQ-029 RST_N=0 SHALL immediately clear all valid bits, set all counters to 01, targets to 0, and MispredictCount to 0, independent of CLK.
REQ-030 While RST_N=0, PredTakenF SHALL be 0 and PredTargetF SHALL be PCF+4.
REQ-031 Reset asserted mid-update SHALL win; no table write SHALL occur on that edge.
REQ-032 The first update SHALL be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-033 Reset, PCF=0x00400010 -> PredTakenF=0, PredTargetF=0x00400014, MispredictCount=0.
REQ-034 UpdateD=1, PCD=0x00400010, ConditionD=1, TargetD=0x00400100, PredTakenD=0 -> MispredictD=1, RedirectPCD=0x00400100; next cycle PCF=0x00400010 gives PredTakenF=1, PredTargetF=0x00400100, MispredictCount=1.
REQ-035 From counter 10, three not-taken updates -> counter 01 then 00 then 00 (saturation); PredTakenF=0 after the first update.
REQ-036 Alias test: allocate PCD=0x00400010, then resolve taken PCD=0x00401010 (same index, different tag) -> entry re-tagged; PCF=0x00400010 then misses with PredTakenF=0.
REQ-037 Same-cycle update and lookup at the same index -> PredTakenF reflects the old entry in that cycle and the new entry in the next cycle.
REQ-038 Force 0xFFFF+1 mispredictions -> MispredictCount holds at 0xFFFF; asserting RST_N=0 mid-run returns it to 0 asynchronously.
